mips_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It fetches an instruction over a req/ack instruction-memory port and holds it in an instruction register. It decodes the instruction and drives the datapath control fields through EXEC, MEM and WB phases, then issues one PC-update pulse per retired instruction. Data-memory access uses a req/ack handshake with a timeout, and multiply gets a fixed wait. Illegal opcodes and bus timeouts put the block in a sticky trap state.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 20 ++
 rtl/mips_decoder.sv | 81 ++++++++
 rtl/mips_multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU/HI-LO codes, FSM states and the control bundle
// for the multi-cycle MIPS sequencer.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam int REG_W  = 5;
  localparam int ALUC_W = 3;
  localparam int MC_W   = 2;

  localparam logic [ALUC_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_MULT = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b111;

  localparam logic [MC_W-1:0] MC_ALU = 2'b00;
  localparam logic [MC_W-1:0] MC_HI  = 2'b01;
  localparam logic [MC_W-1:0] MC_LO  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic              memtoreg;
    logic              alusrcbimm;
    logic [REG_W-1:0]  destreg;
    logic              regwrite;
    logic              branch;
    logic              jump;
    logic [ALUC_W-1:0] alucontrol;
    logic [MC_W-1:0]   multcont;
    logic              lui;
    logic              ori;
    logic              memrd;
    logic              memwr;
    logic              mult;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction- and data-memory req/ack bus between the
// sequencer (master) and the memory system (slave).
interface mips_multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/mips_decoder.sv
// Combinational instruction decode: ir to control bundle
// plus an illegal-instruction flag.
module mips_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign unused_bits = ^{ir[25:21], ir[10:6]};

  always_comb begin
    ctrl = '0;
    ctrl.alucontrol = ALU_ADD;
    ctrl.multcont = MC_ALU;
    illegal = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl.destreg = ir[15:11];
        ctrl.regwrite = 1'b1;
        unique case (1'b1)
          fn == FN_ADD: ctrl.alucontrol = ALU_ADD;
          fn == FN_SUB: ctrl.alucontrol = ALU_SUB;
          fn == FN_AND: ctrl.alucontrol = ALU_AND;
          fn == FN_OR:  ctrl.alucontrol = ALU_OR;
          fn == FN_SLT: ctrl.alucontrol = ALU_SLT;
          fn == FN_MULT: begin
            ctrl.alucontrol = ALU_MULT;
            ctrl.regwrite = 1'b0;
            ctrl.mult = 1'b1;
          end
          fn == FN_MFHI: ctrl.multcont = MC_HI;
          fn == FN_MFLO: ctrl.multcont = MC_LO;
          default: illegal = 1'b1;
        endcase
      end
      op == OP_ADDI: begin
        ctrl.destreg = ir[20:16];
        ctrl.regwrite = 1'b1;
        ctrl.alusrcbimm = 1'b1;
      end
      op == OP_ORI: begin
        ctrl.destreg = ir[20:16];
        ctrl.regwrite = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.ori = 1'b1;
        ctrl.alucontrol = ALU_OR;
      end
      op == OP_LUI: begin
        ctrl.destreg = ir[20:16];
        ctrl.regwrite = 1'b1;
        ctrl.lui = 1'b1;
      end
      op == OP_LW: begin
        ctrl.destreg = ir[20:16];
        ctrl.regwrite = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memrd = 1'b1;
      end
      op == OP_SW: begin
        ctrl.alusrcbimm = 1'b1;
        ctrl.memwr = 1'b1;
      end
      op == OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alucontrol = ALU_SUB;
      end
      op == OP_J: ctrl.jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: fetch, decode, exec, mem, writeback,
// with bus timeouts and a sticky trap state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_LAT    = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  mips_multicycle_ctrl_if.master bus,
  output logic [31:0]   ir,
  input  logic          zero,
  output logic          memtoreg,
  output logic          alusrcbimm,
  output logic [4:0]    destreg,
  output logic          regwrite,
  output logic          dobranch,
  output logic          jump,
  output logic [2:0]    alucontrol,
  output logic [1:0]    multcont,
  output logic          lui,
  output logic          ori,
  output logic          pcen,
  output logic          trap,
  output logic          bus_error,
  output logic [31:0]   instret
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] ML_LAST = 4'(MULT_LAT - 1);

  state_t     state;
  ctrl_t      dec;
  ctrl_t      cq;
  logic       illegal;
  logic [7:0] tcnt;
  logic [3:0] mcnt;
  logic       imem_req_q;
  logic       dmem_req_q;
  logic       dmem_we_q;
  logic       mult_busy;
  logic       is_mem;
  logic       to_hit;
  logic       enter_wb;
  logic       go_trap;

  mips_decoder u_dec (
    .ir      (ir),
    .ctrl    (dec),
    .illegal (illegal)
  );

  assign bus.imem_req = imem_req_q;
  assign bus.dmem_req = dmem_req_q;
  assign bus.dmem_we  = dmem_we_q;

  assign memtoreg   = cq.memtoreg;
  assign alusrcbimm = cq.alusrcbimm;
  assign destreg    = cq.destreg;
  assign alucontrol = cq.alucontrol;
  assign multcont   = cq.multcont;
  assign lui        = cq.lui;
  assign ori        = cq.ori;

  assign mult_busy = cq.mult && (mcnt != ML_LAST);
  assign is_mem    = cq.memrd | cq.memwr;
  assign to_hit    = (tcnt == TO_LAST);

  assign enter_wb =
    (state == S_EXEC && !mult_busy && !is_mem) ||
    (state == S_MEM && bus.dmem_ack);

  // an ack arriving on the last allowed cycle beats the timeout
  assign go_trap =
    (state == S_DECODE && illegal) ||
    (state == S_FETCH && imem_req_q &&
     !bus.imem_ack && to_hit) ||
    (state == S_MEM && !bus.dmem_ack && to_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      ir         <= '0;
      cq         <= '0;
      tcnt       <= '0;
      mcnt       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      regwrite   <= 1'b0;
      pcen       <= 1'b0;
      dobranch   <= 1'b0;
      jump       <= 1'b0;
      trap       <= 1'b0;
      bus_error  <= 1'b0;
      instret    <= '0;
    end else begin
      regwrite <= 1'b0;
      pcen     <= 1'b0;
      dobranch <= 1'b0;
      jump     <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (imem_req_q && bus.imem_ack) begin
            ir         <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end else begin
            imem_req_q <= 1'b1;
            if (imem_req_q) tcnt <= tcnt + 8'd1;
          end
        end
        S_DECODE: begin
          cq    <= dec;
          mcnt  <= '0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (mult_busy) begin
            mcnt <= mcnt + 4'd1;
          end else if (is_mem) begin
            state      <= S_MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= cq.memwr;
            tcnt       <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            state      <= S_WB;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WB: begin
          state      <= S_FETCH;
          imem_req_q <= 1'b1;
          tcnt       <= '0;
          cq         <= '0;
        end
        default: state <= S_TRAP;
      endcase
      if (enter_wb) begin
        pcen     <= 1'b1;
        regwrite <= cq.regwrite;
        dobranch <= cq.branch & zero;
        jump     <= cq.jump;
        instret  <= instret + 32'd1;
      end
      if (go_trap) begin
        state      <= S_TRAP;
        trap       <= 1'b1;
        bus_error  <= (state != S_DECODE);
        imem_req_q <= 1'b0;
        dmem_req_q <= 1'b0;
        dmem_we_q  <= 1'b0;
        cq         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against a
// per-instruction reference model.
module tb_mips_multicycle_ctrl;

  localparam int MLAT = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] ir;
  logic        memtoreg, alusrcbimm, regwrite, dobranch, jump;
  logic [4:0]  destreg;
  logic [2:0]  alucontrol;
  logic [1:0]  multcont;
  logic        lui, ori, pcen, trap, bus_error;
  logic [31:0] instret;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .MULT_LAT    (MLAT),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .ir         (ir),
    .zero       (zero),
    .memtoreg   (memtoreg),
    .alusrcbimm (alusrcbimm),
    .destreg    (destreg),
    .regwrite   (regwrite),
    .dobranch   (dobranch),
    .jump       (jump),
    .alucontrol (alucontrol),
    .multcont   (multcont),
    .lui        (lui),
    .ori        (ori),
    .pcen       (pcen),
    .trap       (trap),
    .bus_error  (bus_error),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = '0;

  typedef struct packed {
    bit       legal;
    bit       rw;
    bit [4:0] dst;
    bit       m2r;
    bit       imm;
    bit       lui;
    bit       ori;
    bit       ld;
    bit       st;
    bit       br;
    bit       jmp;
    bit       mul;
    bit       alu_dc;
    bit [2:0] alu;
    bit [1:0] mc;
  } exp_t;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(logic [31:0] i);
    exp_t e;
    e = '0;
    e.legal = 1;
    e.alu = 3'b010;
    case (i[31:26])
      6'h00: begin
        e.dst = i[15:11];
        e.rw = 1;
        case (i[5:0])
          6'h20: e.alu = 3'b010;
          6'h22: e.alu = 3'b110;
          6'h24: e.alu = 3'b000;
          6'h25: e.alu = 3'b001;
          6'h2A: e.alu = 3'b111;
          6'h18: begin e.alu = 3'b011; e.rw = 0; e.mul = 1; end
          6'h10: begin e.mc = 2'b01; e.alu_dc = 1; end
          6'h12: begin e.mc = 2'b10; e.alu_dc = 1; end
          default: e.legal = 0;
        endcase
      end
      6'h08: begin e.dst = i[20:16]; e.rw = 1; e.imm = 1; end
      6'h0D: begin
        e.dst = i[20:16]; e.rw = 1; e.imm = 1;
        e.ori = 1; e.alu = 3'b001;
      end
      6'h0F: begin
        e.dst = i[20:16]; e.rw = 1; e.lui = 1; e.alu_dc = 1;
      end
      6'h23: begin
        e.dst = i[20:16]; e.rw = 1; e.imm = 1;
        e.m2r = 1; e.ld = 1;
      end
      6'h2B: begin e.imm = 1; e.st = 1; end
      6'h04: begin e.br = 1; e.alu = 3'b110; end
      6'h02: begin e.jmp = 1; e.alu_dc = 1; end
      default: e.legal = 0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [8];
    logic [5:0]  bad_ops [4];
    logic [31:0] r;
    int          k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h10, 6'h12};
    bad_ops = '{6'h3F, 6'h01, 6'h05, 6'h20};
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 8) return {6'h00, r[25:6], fns[k]};
    case (k)
      8:  return {6'h08, r[25:0]};
      9:  return {6'h0D, r[25:0]};
      10: return {6'h0F, r[25:0]};
      11: return {6'h23, r[25:0]};
      12: return {6'h2B, r[25:0]};
      13: return (r[0]) ? {6'h04, r[25:0]} : {6'h02, r[25:0]};
      14: return {bad_ops[r[1:0]], r[25:0]};
      default: return {6'h00, r[25:6], 6'h3F};
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    @(negedge clk);
    check("rst_ir", ir, 0);
    check("rst_instret", instret, 0);
    check("rst_trap", {trap, bus_error, pcen, regwrite}, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_ret = '0;
  endtask

  // res: 0 retired, 1 trapped, 2 cycle budget exhausted
  task automatic run_instr(input logic [31:0] instr, input int idly,
                           input int ddly, input logic zv,
                           output int res);
    exp_t e;
    int   ic, dc, lat, stray;
    bit   started;
    e = model(instr);
    ic = 0; dc = 0; lat = 0; stray = 0; started = 0;
    zero = zv;
    res = 2;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.imem_rdata = $urandom;
      if (started) lat++;
      if (trap) begin res = 1; break; end
      if (pcen) begin
        check("wb_regwrite", regwrite, e.rw);
        check("wb_destreg", destreg, e.dst);
        check("wb_memtoreg", memtoreg, e.m2r);
        check("wb_alusrcbimm", alusrcbimm, e.imm);
        if (!e.alu_dc) check("wb_alucontrol", alucontrol, e.alu);
        check("wb_multcont", multcont, e.mc);
        check("wb_lui_ori", {lui, ori}, {e.lui, e.ori});
        check("wb_dobranch", dobranch, e.br & zv);
        check("wb_jump", jump, e.jmp);
        check("latency", lat,
              4 + ((e.ld | e.st) ? ddly : 0) + (e.mul ? MLAT - 1 : 0));
        check("dmem_req_cycles", dc, (e.ld | e.st) ? ddly : 0);
        check("ir", ir, instr);
        exp_ret++;
        check("instret", instret, exp_ret);
        res = 0;
        break;
      end
      if (regwrite | dobranch | jump) stray++;
      if (bus.imem_req) begin
        ic++;
        if (ic == idly) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = instr;
          started = 1;
          lat = 1;
        end
      end
      if (bus.dmem_req) begin
        if (dc == 0) check("dmem_we", bus.dmem_we, e.st);
        dc++;
        if (dc == ddly) bus.dmem_ack = 1'b1;
      end
    end
    check("stray_strobes", stray, 0);
  endtask

  task automatic step(input logic [31:0] instr, input int idly,
                      input int ddly, input logic zv);
    exp_t e;
    int   res;
    int   want;
    bit   want_be;
    e = model(instr);
    want_be = (idly > TMO) || (e.legal && (e.ld | e.st) && ddly > TMO);
    want = (want_be || !e.legal) ? 1 : 0;
    run_instr(instr, idly, ddly, zv, res);
    check("outcome", res, want);
    if (res == 1) begin
      check("bus_error", bus_error, want_be);
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      bus.imem_rdata = 32'h20080005;
      repeat (2) @(negedge clk);
      check("trap_hold", {trap, bus.imem_req, bus.dmem_req, pcen},
            4'b1000);
      check("trap_fields", {destreg, alucontrol, alusrcbimm}, 0);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    bit got;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.imem_rdata = '0;
    do_reset();

    step(32'h20080005, 1, 1, 1'b0);
    step(32'h8D090004, 1, 3, 1'b0);
    step(32'hAD090004, 2, 1, 1'b0);
    step(32'h1109FFFF, 1, 1, 1'b1);
    step(32'h1109FFFF, 3, 1, 1'b0);
    step(32'h08000010, 1, 1, 1'b0);
    step(32'h01090018, 1, 1, 1'b0);
    step(32'h00005010, 1, 1, 1'b0);
    step(32'h3F000000, 1, 1, 1'b0);
    step(32'h20080005, TMO, 1, 1'b0);
    step(32'h20080005, TMO + 1, 1, 1'b0);
    step(32'h8D090004, 1, TMO, 1'b0);
    step(32'h8D090004, 1, TMO + 1, 1'b0);

    for (int n = 0; n < 60; n++)
      step(rand_instr(), $urandom_range(1, 4),
           $urandom_range(1, 4), 1'($urandom_range(0, 1)));

    do_reset();
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      if (bus.dmem_req) begin got = 1; break; end
      if (bus.imem_req) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hAD090004;
      end
    end
    check("sw_in_mem", got, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_dmem", {bus.dmem_req, bus.dmem_we}, 0);
    check("abort_strobes", {pcen, regwrite}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_instret", instret, 0);
    check("abort_refetch", bus.imem_req, 1);

    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.instret;
    check("preload", instret, 32'hFFFF_FFFF);
    exp_ret = 32'hFFFF_FFFF;
    step(32'h20080005, 1, 1, 1'b0);
    check("wrap", instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
